dm_arbiter: RTL and testbench
=============================

DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: consecutive CPU wins over a pending ext request before ext is forced through.
REQ-002 SHALL have port clk  in  1  rising-edge clock.
REQ-003 SHALL have port clr_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port cpu_req  in  1  MEM-stage data-memory access this cycle (already gated by writeback mask).
REQ-005 SHALL have port cpu_rd  in  1  1=read, 0=write.
REQ-006 SHALL have port cpu_addr  in  8  word address.
REQ-007 SHALL have port cpu_wdata  in  32  write data.
REQ-008 SHALL have port cpu_stall  out  1  CPU access not performed this cycle; hold pipeline.
REQ-009 SHALL have port cpu_rdata  out  32  read data, combinational from mem_rdata.
REQ-010 SHALL have ports ext_req / ext_rd / ext_addr / ext_wdata  in  1/1/8/32  secondary (debug/DMA) port; request level-held until ext_ack.
REQ-011 SHALL have port ext_ack  out  1  registered one-cycle completion pulse.
REQ-012 SHALL have port ext_rdata  out  32  registered read data, valid with ext_ack.
REQ-013 SHALL have ports mem_cs / mem_rd / mem_addr / mem_wdata  out  1/1/8/32  to data RAM (sync write, combinational read).
REQ-014 SHALL have port mem_rdata  in  32  RAM read data.

Function
REQ-015 SHALL implement FSM {IDLE, ACK}; ACK lasts exactly one cycle, then IDLE.
REQ-016 In IDLE, ext wins iff ext_req=1 and (cpu_req=0 or starve_cnt==STARVE_LIMIT); otherwise CPU wins if cpu_req=1.
REQ-017 In ACK, ext_req SHALL be ignored; CPU wins if cpu_req=1.
REQ-018 Winner's rd/addr/wdata SHALL drive mem_* combinationally with mem_cs=1; no requester -> mem_cs=0, mem_addr/mem_wdata=0, mem_rd=1.
REQ-019 cpu_stall SHALL equal cpu_req AND ext-won, same cycle; CPU access completes in the cycle it is granted (zero added latency).
REQ-020 Ext win in IDLE SHALL transition to ACK; at that edge ext_rdata <= mem_rdata if ext_rd=1, else retains; ext_ack=1 during ACK only.
REQ-021 Ext latency: request accepted -> ext_ack exactly 1 cycle later; minimum spacing between ext accesses 2 cycles.
REQ-022 starve_cnt SHALL increment (saturating at STARVE_LIMIT) each IDLE cycle where ext_req=1 and CPU wins; clear on ext win; hold otherwise.
REQ-023 Simultaneous cpu_req and ext_req with counter saturated: ext served, CPU stalled exactly one cycle, CPU served in ACK.

Reset
REQ-024 On clr_n=0: state=IDLE, starve_cnt=0, ext_ack=0, ext_rdata=0, immediately and independent of clk.
REQ-025 Reset during ACK SHALL drop the pending ext_ack; ext requester must reissue.

Configuration
REQ-026 Macro DM_ARB_FAIRNESS_EN defined: starvation counter per REQ-016/022 active.
REQ-027 Macro undefined: strict CPU priority, ext wins only when cpu_req=0, no counter logic, STARVE_LIMIT unused; cpu_stall then constant 0.

Structure
REQ-028 Package dm_arb_pkg SHALL hold state enum, DM_ADDR_W=8, DM_DATA_W=32.
REQ-029 Sub-module dm_arb_starve_cnt (saturating counter) SHALL exist, instantiated only under DM_ARB_FAIRNESS_EN.

Verification
REQ-030 Ext read addr 0x10 (RAM=0xDEADBEEF), cpu_req=0 -> mem_cs=1, ext_ack next cycle, ext_rdata=0xDEADBEEF.
REQ-031 cpu_req and ext_req held high, fairness on, STARVE_LIMIT=4 -> CPU wins 4 cycles, 5th cycle ext wins with cpu_stall=1, 6th cycle CPU wins with ext_ack=1.
REQ-032 Same stimulus, macro undefined -> ext never granted, cpu_stall always 0.
REQ-033 Ext write 0x12345678 to addr 0x20, then CPU read 0x20 -> cpu_rdata=0x12345678; ext_rdata unchanged.
REQ-034 clr_n pulled low mid-ACK -> ext_ack=0, state IDLE, ext_rdata=0 without clock edge.
REQ-035 ext_req held through ACK cycle -> second access issued only in following IDLE cycle, two distinct ext_ack pulses 2 cycles apart.

Source files
------------

// File: rtl/dm_arb_pkg.sv
// -----------------------------------------------------------------------------
// dm_arb_pkg
// Shared types and constants for the data-memory arbiter.
//   DM_ADDR_W / DM_DATA_W : data RAM word-address and data widths
//   dm_arb_state_e        : arbiter FSM states (IDLE, ACK)
//   dm_mem_req_t          : one RAM access (rd/addr/wdata) as presented to the RAM
//   dm_cnt_w()            : width of a counter able to hold 0..limit
// -----------------------------------------------------------------------------
package dm_arb_pkg;

   localparam int DM_ADDR_W = 8;
   localparam int DM_DATA_W = 32;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_ACK  = 1'b1
   } dm_arb_state_e;

   typedef struct packed {
      logic                 rd;
      logic [DM_ADDR_W-1:0] addr;
      logic [DM_DATA_W-1:0] wdata;
   } dm_mem_req_t;

   // Value driven to the RAM when nobody is granted: a harmless read of word 0.
   localparam dm_mem_req_t DM_REQ_NONE = '{rd: 1'b1, addr: '0, wdata: '0};

   // Width needed to count from 0 up to and including limit (never below 1 bit).
   function automatic int dm_cnt_w(input int limit);
      return (limit < 1) ? 1 : $clog2(limit + 1);
   endfunction

endpackage : dm_arb_pkg

// File: rtl/dm_arb_starve_cnt.sv
// -----------------------------------------------------------------------------
// dm_arb_starve_cnt
// Saturating counter of how many times in a row the secondary port has been
// refused in favour of the CPU. Saturates at LIMIT; sat_o flags saturation.
// Ports:
//   clk    in  rising-edge clock
//   clr_n  in  asynchronous active-low reset (count -> 0)
//   inc_i  in  count one more refusal (ignored once saturated)
//   clr_i  in  secondary port was served; restart from 0 (wins over inc_i)
//   sat_o  out count has reached LIMIT
// -----------------------------------------------------------------------------
module dm_arb_starve_cnt
   import dm_arb_pkg::*;
#(
   parameter int LIMIT = 4
) (
   input  logic clk,
   input  logic clr_n,
   input  logic inc_i,
   input  logic clr_i,
   output logic sat_o
);

   localparam int               CNT_W   = dm_cnt_w(LIMIT);
   localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != LIMIT_C)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign sat_o = (cnt_q == LIMIT_C);

endmodule : dm_arb_starve_cnt

// File: rtl/dm_arbiter.sv
// -----------------------------------------------------------------------------
// dm_arbiter
// Shares one single-port data RAM between the CPU MEM stage and a secondary
// (debug/DMA) port. The CPU access is combinational and completes in the cycle
// it is granted; a secondary access takes one grant cycle followed by one ACK
// cycle, during which the secondary request is ignored.
//
// Build option: define DM_ARB_FAIRNESS_EN to enable the starvation counter,
// which forces a pending secondary request through after STARVE_LIMIT
// consecutive CPU wins (the CPU then stalls for that one cycle). Without the
// macro the CPU has strict priority and cpu_stall is tied low.
//
// Ports:
//   clk, clr_n                   clock, asynchronous active-low reset
//   cpu_req/cpu_rd/cpu_addr/cpu_wdata  CPU access this cycle
//   cpu_stall                    CPU access not performed this cycle
//   cpu_rdata                    RAM read data (combinational)
//   ext_req/ext_rd/ext_addr/ext_wdata  secondary access, held until ext_ack
//   ext_ack                      registered one-cycle completion pulse
//   ext_rdata                    registered read data, valid with ext_ack
//   mem_cs/mem_rd/mem_addr/mem_wdata   RAM request (sync write, comb read)
//   mem_rdata                    RAM read data
// -----------------------------------------------------------------------------
module dm_arbiter
   import dm_arb_pkg::*;
#(
   parameter int STARVE_LIMIT = 4
) (
   input  logic                 clk,
   input  logic                 clr_n,
   // CPU port
   input  logic                 cpu_req,
   input  logic                 cpu_rd,
   input  logic [DM_ADDR_W-1:0] cpu_addr,
   input  logic [DM_DATA_W-1:0] cpu_wdata,
   output logic                 cpu_stall,
   output logic [DM_DATA_W-1:0] cpu_rdata,
   // secondary port
   input  logic                 ext_req,
   input  logic                 ext_rd,
   input  logic [DM_ADDR_W-1:0] ext_addr,
   input  logic [DM_DATA_W-1:0] ext_wdata,
   output logic                 ext_ack,
   output logic [DM_DATA_W-1:0] ext_rdata,
   // data RAM
   output logic                 mem_cs,
   output logic                 mem_rd,
   output logic [DM_ADDR_W-1:0] mem_addr,
   output logic [DM_DATA_W-1:0] mem_wdata,
   input  logic [DM_DATA_W-1:0] mem_rdata
);

   dm_arb_state_e        state_q;
   dm_arb_state_e        state_d;
   logic [DM_DATA_W-1:0] ext_rdata_q;
   logic [DM_DATA_W-1:0] ext_rdata_d;

   logic                 in_idle;
   logic                 ext_pri;   // secondary port may pre-empt a CPU request
   logic                 ext_win;
   logic                 cpu_win;
   dm_mem_req_t          mem_req;

`ifdef DM_ARB_FAIRNESS_EN
   logic starve_inc;
   logic starve_sat;

   // Only refusals while the secondary request is actually eligible (IDLE)
   // count; the ACK cycle ignores ext_req and must not age it.
   assign starve_inc = in_idle & ext_req & cpu_win;

   dm_arb_starve_cnt #(
      .LIMIT (STARVE_LIMIT)
   ) u_starve_cnt (
      .clk   (clk),
      .clr_n (clr_n),
      .inc_i (starve_inc),
      .clr_i (ext_win),
      .sat_o (starve_sat)
   );

   assign ext_pri   = starve_sat;
   assign cpu_stall = cpu_req & ext_win;
`else
   // Strict CPU priority: the secondary port never displaces the CPU, so the
   // CPU never stalls and the starvation limit has no effect.
   logic unused_starve_limit;
   assign unused_starve_limit = (STARVE_LIMIT != 0);
   assign ext_pri   = 1'b0;
   assign cpu_stall = 1'b0;
`endif

   // Arbitration
   always_comb begin
      in_idle = (state_q == ST_IDLE);
      ext_win = in_idle & ext_req & (~cpu_req | ext_pri);
      cpu_win = cpu_req & ~ext_win;
   end

   // RAM request mux and next state
   always_comb begin
      mem_req     = DM_REQ_NONE;
      mem_cs      = 1'b0;
      state_d     = ST_IDLE;
      ext_rdata_d = ext_rdata_q;

      if (ext_win) begin
         mem_cs        = 1'b1;
         mem_req.rd    = ext_rd;
         mem_req.addr  = ext_addr;
         mem_req.wdata = ext_wdata;
      end else if (cpu_win) begin
         mem_cs        = 1'b1;
         mem_req.rd    = cpu_rd;
         mem_req.addr  = cpu_addr;
         mem_req.wdata = cpu_wdata;
      end

      // ACK always lasts a single cycle; only a secondary win leaves IDLE.
      if (ext_win) begin
         state_d = ST_ACK;
         if (ext_rd) begin
            ext_rdata_d = mem_rdata;
         end
      end
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state_q     <= ST_IDLE;
         ext_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         ext_rdata_q <= ext_rdata_d;
      end
   end

   assign mem_rd    = mem_req.rd;
   assign mem_addr  = mem_req.addr;
   assign mem_wdata = mem_req.wdata;

   // ext_ack comes straight from the state register, so reset clears it
   // immediately and a pending completion is dropped.
   assign ext_ack   = (state_q == ST_ACK);
   assign ext_rdata = ext_rdata_q;
   assign cpu_rdata = mem_rdata;

endmodule : dm_arbiter

// File: tb/tb_dm_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dm_arbiter
// Self-checking bench for dm_arbiter with a behavioural RAM and a cycle-level
// reference model of the arbitration rules. Follows DM_ARB_FAIRNESS_EN.
// -----------------------------------------------------------------------------
module tb_dm_arbiter;

   localparam int LIMIT = 4;
`ifdef DM_ARB_FAIRNESS_EN
   localparam bit FAIR = 1'b1;
`else
   localparam bit FAIR = 1'b0;
`endif

   logic        clk;
   logic        clr_n;
   logic        cpu_req;
   logic        cpu_rd;
   logic [7:0]  cpu_addr;
   logic [31:0] cpu_wdata;
   logic        cpu_stall;
   logic [31:0] cpu_rdata;
   logic        ext_req;
   logic        ext_rd;
   logic [7:0]  ext_addr;
   logic [31:0] ext_wdata;
   logic        ext_ack;
   logic [31:0] ext_rdata;
   logic        mem_cs;
   logic        mem_rd;
   logic [7:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   dm_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
      .clk       (clk),
      .clr_n     (clr_n),
      .cpu_req   (cpu_req),
      .cpu_rd    (cpu_rd),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_stall (cpu_stall),
      .cpu_rdata (cpu_rdata),
      .ext_req   (ext_req),
      .ext_rd    (ext_rd),
      .ext_addr  (ext_addr),
      .ext_wdata (ext_wdata),
      .ext_ack   (ext_ack),
      .ext_rdata (ext_rdata),
      .mem_cs    (mem_cs),
      .mem_rd    (mem_rd),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   // Behavioural data RAM: synchronous write, combinational read, preload port.
   logic [31:0] ram [0:255];
   logic        pre_we;
   logic [7:0]  pre_addr;
   logic [31:0] pre_data;

   always @(posedge clk) begin
      if (pre_we) ram[pre_addr] <= pre_data;
      else if (mem_cs && !mem_rd) ram[mem_addr] <= mem_wdata;
   end
   assign mem_rdata = ram[mem_addr];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   int total = 0;
   int bad   = 0;

   // Reference model: cycle index of the last accepted secondary request, how
   // many eligible cycles it has been refused, and a mirror of RAM contents.
   int          cyc;
   int          last_ext;
   int          refused;
   logic [31:0] m_ext_rdata;
   logic [31:0] mref [0:255];

   bit          x_in_ack, x_ext_win, x_cpu_win;
   logic        x_cs, x_rd, x_stall, x_ack;
   logic [7:0]  x_addr;
   logic [31:0] x_wdata, x_cpu_rdata, x_ext_rdata;

   task automatic model_reset();
      last_ext    = -10;
      refused     = 0;
      m_ext_rdata = '0;
   endtask

   task automatic model_eval();
      x_in_ack  = (cyc == last_ext + 1);
      x_ext_win = (ext_req == 1'b1) && !x_in_ack &&
                  ((cpu_req == 1'b0) || (FAIR && refused >= LIMIT));
      x_cpu_win = (cpu_req == 1'b1) && !x_ext_win;
      x_stall   = (cpu_req == 1'b1) && x_ext_win;
      x_ack     = x_in_ack;
      if (x_ext_win) begin
         x_cs = 1'b1; x_rd = ext_rd; x_addr = ext_addr; x_wdata = ext_wdata;
      end else if (x_cpu_win) begin
         x_cs = 1'b1; x_rd = cpu_rd; x_addr = cpu_addr; x_wdata = cpu_wdata;
      end else begin
         x_cs = 1'b0; x_rd = 1'b1; x_addr = '0; x_wdata = '0;
      end
      x_cpu_rdata = mref[x_addr];
      x_ext_rdata = m_ext_rdata;
   endtask

   task automatic model_commit();
      if (x_ext_win) begin
         last_ext = cyc;
         refused  = 0;
         if (ext_rd) m_ext_rdata = mref[ext_addr];
         else        mref[ext_addr] = ext_wdata;
      end else if (x_cpu_win && ext_req && !x_in_ack && refused < LIMIT) begin
         refused = refused + 1;
      end
      if (x_cpu_win && !cpu_rd) mref[cpu_addr] = cpu_wdata;
      cyc = cyc + 1;
   endtask

   task automatic drive(input logic cr, input logic crd, input logic [7:0] ca,
                        input logic [31:0] cw, input logic er, input logic erd,
                        input logic [7:0] ea, input logic [31:0] ew);
      @(negedge clk);
      cpu_req = cr; cpu_rd = crd; cpu_addr = ca; cpu_wdata = cw;
      ext_req = er; ext_rd = erd; ext_addr = ea; ext_wdata = ew;
      #1;
      model_eval();
   endtask

   task automatic advance();
      @(posedge clk);
      model_commit();
   endtask

   task automatic test_reset();
      clr_n = 1'b0; pre_we = 1'b0; pre_addr = '0; pre_data = '0;
      cpu_req = 0; cpu_rd = 1; cpu_addr = '0; cpu_wdata = '0;
      ext_req = 0; ext_rd = 1; ext_addr = '0; ext_wdata = '0;
      #1;
      total++; if (ext_ack !== 1'b0) begin bad++; $display("FAIL reset_ack got=%b exp=0", ext_ack); end
      total++; if (ext_rdata !== 32'h0) begin bad++; $display("FAIL reset_ext_rdata got=%h exp=0", ext_rdata); end
      total++; if (cpu_stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", cpu_stall); end
      total++; if (mem_cs !== 1'b0) begin bad++; $display("FAIL reset_cs got=%b exp=0", mem_cs); end
      total++; if (mem_rd !== 1'b1) begin bad++; $display("FAIL reset_mem_rd got=%b exp=1", mem_rd); end
      total++; if (mem_addr !== 8'h0) begin bad++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); end
      total++; if (mem_wdata !== 32'h0) begin bad++; $display("FAIL reset_mem_wdata got=%h exp=0", mem_wdata); end
      for (int a = 0; a < 256; a++) begin
         @(negedge clk);
         pre_we   = 1'b1;
         pre_addr = 8'(a);
         pre_data = (a == 16) ? 32'hDEADBEEF : $urandom;
         mref[a]  = pre_data;
      end
      @(negedge clk);
      pre_we = 1'b0;
      total++; if (ext_ack !== 1'b0) begin bad++; $display("FAIL reset_hold_ack got=%b exp=0", ext_ack); end
      clr_n = 1'b1;
      cyc = 0;
      model_reset();
   endtask

   task automatic test_ext_read();
      drive(0, 1, 8'h00, 0, 1, 1, 8'h10, 0);
      total++; if (mem_cs !== 1'b1) begin bad++; $display("FAIL rd_cs got=%b exp=1", mem_cs); end
      total++; if (mem_addr !== 8'h10) begin bad++; $display("FAIL rd_addr got=%h exp=10", mem_addr); end
      total++; if (mem_rd !== 1'b1) begin bad++; $display("FAIL rd_mem_rd got=%b exp=1", mem_rd); end
      total++; if (ext_ack !== 1'b0) begin bad++; $display("FAIL rd_early_ack got=%b exp=0", ext_ack); end
      advance();
      drive(0, 1, 8'h00, 0, 1, 1, 8'h10, 0);
      total++; if (ext_ack !== 1'b1) begin bad++; $display("FAIL rd_ack got=%b exp=1", ext_ack); end
      total++; if (ext_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_data got=%h exp=deadbeef", ext_rdata); end
      total++; if (mem_cs !== 1'b0) begin bad++; $display("FAIL rd_ack_cs got=%b exp=0", mem_cs); end
      advance();
      drive(0, 1, 8'h00, 0, 0, 1, 8'h00, 0);
      total++; if (ext_ack !== 1'b0) begin bad++; $display("FAIL rd_ack_end got=%b exp=0", ext_ack); end
      advance();
   endtask

   task automatic test_ext_write_cpu_read();
      drive(0, 1, 8'h00, 0, 1, 0, 8'h20, 32'h12345678);
      total++; if (mem_cs !== 1'b1 || mem_rd !== 1'b0) begin bad++; $display("FAIL wr_cs_rd got=%b%b exp=10", mem_cs, mem_rd); end
      total++; if (mem_wdata !== 32'h12345678) begin bad++; $display("FAIL wr_wdata got=%h exp=12345678", mem_wdata); end
      advance();
      drive(0, 1, 8'h00, 0, 1, 0, 8'h20, 32'h12345678);
      total++; if (ext_ack !== 1'b1) begin bad++; $display("FAIL wr_ack got=%b exp=1", ext_ack); end
      advance();
      drive(1, 1, 8'h20, 0, 0, 1, 8'h00, 0);
      total++; if (cpu_rdata !== 32'h12345678) begin bad++; $display("FAIL wr_cpu_rdata got=%h exp=12345678", cpu_rdata); end
      total++; if (ext_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL wr_ext_rdata got=%h exp=deadbeef", ext_rdata); end
      total++; if (cpu_stall !== 1'b0) begin bad++; $display("FAIL wr_stall got=%b exp=0", cpu_stall); end
      advance();
   endtask

   task automatic test_starvation();
      logic       e_stall, e_ack;
      logic [7:0] e_addr;
      for (int i = 0; i < 6; i++) begin
         drive(1, 1, 8'(8'h30 + i), 0, 1, 1, 8'h40, 0);
         e_stall = FAIR && (i == 4);
         e_ack   = FAIR && (i == 5);
         e_addr  = (FAIR && i == 4) ? 8'h40 : 8'(8'h30 + i);
         total++; if (cpu_stall !== e_stall) begin bad++; $display("FAIL starve_stall[%0d] got=%b exp=%b", i, cpu_stall, e_stall); end
         total++; if (ext_ack !== e_ack) begin bad++; $display("FAIL starve_ack[%0d] got=%b exp=%b", i, ext_ack, e_ack); end
         total++; if (mem_addr !== e_addr) begin bad++; $display("FAIL starve_addr[%0d] got=%h exp=%h", i, mem_addr, e_addr); end
         advance();
      end
      drive(0, 1, 8'h00, 0, 1, 1, 8'h40, 0);
      total++; if (mem_addr !== 8'h40 || mem_cs !== 1'b1) begin bad++; $display("FAIL starve_release got=%b/%h exp=1/40", mem_cs, mem_addr); end
      advance();
      drive(0, 1, 8'h00, 0, 0, 1, 8'h00, 0);
      advance();
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 5; i++) begin
         drive(0, 1, 8'h00, 0, 1, 0, 8'h50, 32'(i + 100));
         total++; if (mem_cs !== 1'((i % 2) == 0)) begin bad++; $display("FAIL b2b_cs[%0d] got=%b exp=%b", i, mem_cs, 1'((i % 2) == 0)); end
         total++; if (ext_ack !== 1'((i % 2) == 1)) begin bad++; $display("FAIL b2b_ack[%0d] got=%b exp=%b", i, ext_ack, 1'((i % 2) == 1)); end
         advance();
      end
      drive(0, 1, 8'h00, 0, 0, 1, 8'h00, 0);
      total++; if (ext_ack !== 1'b1) begin bad++; $display("FAIL b2b_last_ack got=%b exp=1", ext_ack); end
      advance();
   endtask

   task automatic test_reset_mid_ack();
      drive(0, 1, 8'h00, 0, 1, 1, 8'h10, 0);
      advance();
      drive(0, 1, 8'h00, 0, 1, 1, 8'h10, 0);
      total++; if (ext_ack !== 1'b1) begin bad++; $display("FAIL rst_pre_ack got=%b exp=1", ext_ack); end
      #1 clr_n = 1'b0;
      #1;
      total++; if (ext_ack !== 1'b0) begin bad++; $display("FAIL rst_async_ack got=%b exp=0", ext_ack); end
      total++; if (ext_rdata !== 32'h0) begin bad++; $display("FAIL rst_async_rdata got=%h exp=0", ext_rdata); end
      cpu_req = 0; ext_req = 0;
      model_reset();
      @(posedge clk);
      @(negedge clk);
      clr_n = 1'b1;
      drive(0, 1, 8'h00, 0, 1, 1, 8'h10, 0);
      total++; if (mem_cs !== 1'b1 || mem_addr !== 8'h10) begin bad++; $display("FAIL rst_idle_grant got=%b/%h exp=1/10", mem_cs, mem_addr); end
      advance();
      drive(0, 1, 8'h00, 0, 1, 1, 8'h10, 0);
      total++; if (ext_rdata !== x_ext_rdata) begin bad++; $display("FAIL rst_reissue_rdata got=%h exp=%h", ext_rdata, x_ext_rdata); end
      advance();
      drive(0, 1, 8'h00, 0, 0, 1, 8'h00, 0);
      advance();
   endtask

   task automatic test_random();
      bit          pend = 0;
      logic        p_rd = 1'b1;
      logic [7:0]  p_addr = '0;
      logic [31:0] p_wd = '0;
      for (int n = 0; n < 600; n++) begin
         if (!pend && $urandom_range(0, 2) == 0) begin
            pend = 1; p_rd = 1'($urandom); p_addr = 8'($urandom_range(0, 15)); p_wd = $urandom;
         end
         drive(1'($urandom_range(0, 9) < 7), 1'($urandom), 8'($urandom_range(0, 15)), $urandom,
               pend, p_rd, p_addr, p_wd);
         total++;
         if (mem_cs !== x_cs || mem_rd !== x_rd || mem_addr !== x_addr || mem_wdata !== x_wdata) begin
            bad++;
            $display("FAIL rand_mem[%0d] got=%b %b %h %h exp=%b %b %h %h", n,
                     mem_cs, mem_rd, mem_addr, mem_wdata, x_cs, x_rd, x_addr, x_wdata);
         end
         total++; if (cpu_stall !== x_stall) begin bad++; $display("FAIL rand_stall[%0d] got=%b exp=%b", n, cpu_stall, x_stall); end
         total++; if (ext_ack !== x_ack) begin bad++; $display("FAIL rand_ack[%0d] got=%b exp=%b", n, ext_ack, x_ack); end
         total++; if (ext_rdata !== x_ext_rdata) begin bad++; $display("FAIL rand_ext_rdata[%0d] got=%h exp=%h", n, ext_rdata, x_ext_rdata); end
         total++; if (cpu_rdata !== x_cpu_rdata) begin bad++; $display("FAIL rand_cpu_rdata[%0d] got=%h exp=%h", n, cpu_rdata, x_cpu_rdata); end
         if (x_ack) pend = 0;
         advance();
      end
   endtask

   initial begin
      test_reset();
      test_ext_read();
      test_ext_write_cpu_read();
      test_starvation();
      test_back_to_back();
      test_reset_mid_ack();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_dm_arbiter
